// File: rtl/hash_bits_off_counter.sv
// Serially popcounts one HASH_BITS-long XORed hash and tracks the lowest count seen.
// Result valid HASH_BITS+1 cycles after start; held in DONE until valid_o && ready_i.
module hash_bits_off_counter #(
    parameter int HASH_BITS = 1024,
    parameter int CNT_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             bit_i,
    output logic             write_o,
    output logic             shift_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bits_off_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             new_best_o,
    output logic [CNT_W-1:0] best_o,
    input  logic             clear_best_i
);

    localparam int IDX_W = (CNT_W > 1) ? CNT_W - 1 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HASH_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   bits_off_q, bits_off_d;
    logic [CNT_W-1:0]   best_q, best_d;
    logic [CNT_W-1:0]   acc_sum;
    logic               handshake;

    // Accumulator is one bit wider than the index, so HASH_BITS ones cannot wrap.
    assign acc_sum   = acc_q + {{(CNT_W-1){1'b0}}, bit_i};
    assign handshake = valid_o && ready_i;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        bits_off_d = bits_off_q;
        best_d     = best_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_d   = '0;
                idx_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    bits_off_d = acc_sum;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (handshake) begin
                    state_d = IDLE;
                    if (new_best_o) begin
                        best_d = bits_off_q;
                    end
                end
            end
        endcase
        // A clear wins over a best update landing on the same edge.
        if (clear_best_i) begin
            best_d = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            bits_off_q <= '0;
            best_q     <= '1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            bits_off_q <= bits_off_d;
            best_q     <= best_d;
        end
    end

    assign write_o    = (state_q == LOAD);
    assign shift_o    = (state_q == SHIFT);
    assign busy_o     = (state_q != IDLE);
    assign valid_o    = (state_q == DONE);
    assign bits_off_o = bits_off_q;
    assign best_o     = best_q;
    assign new_best_o = valid_o && (bits_off_q < best_q);

endmodule
